// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package cla_pkg;

  localparam int CLA_BLOCK_W = 4;

  function automatic int num_blocks(input int n);
    return (n + CLA_BLOCK_W - 1) / CLA_BLOCK_W;
  endfunction

endpackage

// File: rtl/cla_block4.sv
// 4-bit lookahead block: all internal carries are flat sum-of-products of g, p and cin.
module cla_block4
  import cla_pkg::*;
(
  input  logic [CLA_BLOCK_W-1:0] g,
  input  logic [CLA_BLOCK_W-1:0] p,
  input  logic                   cin,
  output logic [CLA_BLOCK_W-1:0] c,
  output logic                   grp_g,
  output logic                   grp_p
);

  // c[i] is the carry out of bit i of this block
  always_comb begin
    c[0]  = g[0] | (p[0] & cin);
    c[1]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    c[3]  = grp_g | (grp_p & cin);
  end

endmodule

// File: rtl/cla_adder_reg.sv
// N-bit carry-lookahead adder with registered sum/carry-out.
// Define CLA_ADDER_INPUT_REG_EN to register the inputs as well (latency 2 instead of 1).
module cla_adder_reg
  import cla_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         out_valid
);

  localparam int NB = num_blocks(N);
  localparam int NP = NB * CLA_BLOCK_W;
  localparam logic [NP-1:0] CO_SEL = NP'(1) << (N - 1);

  logic [N-1:0] core_a, core_b;
  logic         core_c, core_v;

`ifdef CLA_ADDER_INPUT_REG_EN
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         c_in_q, c_in_d, in_valid_q, in_valid_d;

  always_comb begin
    a_d        = a;
    b_d        = b;
    c_in_d     = c_in;
    in_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      c_in_q     <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      c_in_q     <= c_in_d;
      in_valid_q <= in_valid_d;
    end
  end

  assign core_a = a_q;
  assign core_b = b_q;
  assign core_c = c_in_q;
  assign core_v = in_valid_q;
`else
  assign core_a = a;
  assign core_b = b;
  assign core_c = c_in;
  assign core_v = in_valid;
`endif

  // Bit-level generate/propagate; padding bits of a partial top block stay 0
  logic [NP-1:0] g_pad, p_pad, co_all, c_into;
  logic [NB-1:0] grp_g, grp_p, blk_cin, pre_g, pre_p;
  logic [NB:0]   blk_c;

  always_comb begin
    g_pad        = '0;
    p_pad        = '0;
    g_pad[N-1:0] = core_a & core_b;
    p_pad[N-1:0] = core_a ^ core_b;
  end

  for (genvar j = 0; j < NB; j++) begin : g_blk
    cla_block4 u_blk (
      .g     (g_pad[j*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .p     (p_pad[j*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .cin   (blk_cin[j]),
      .c     (co_all[j*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .grp_g (grp_g[j]),
      .grp_p (grp_p[j])
    );
  end

  // Second level: log-depth parallel prefix over group G/P. Descending j within
  // a level means pre_*[j-d] still holds the previous level's value.
  always_comb begin
    pre_g = grp_g;
    pre_p = grp_p;
    for (int d = 1; d < NB; d = d * 2) begin
      for (int j = NB - 1; j >= d; j--) begin
        pre_g[j] = pre_g[j] | (pre_p[j] & pre_g[j-d]);
        pre_p[j] = pre_p[j] & pre_p[j-d];
      end
    end
    blk_c[0] = core_c;
    for (int j = 0; j < NB; j++) begin
      blk_c[j+1] = pre_g[j] | (pre_p[j] & core_c);
    end
  end

  assign blk_cin = blk_c[NB-1:0];

  always_comb begin
    c_into = {co_all[NP-2:0], 1'b0};
    for (int j = 0; j < NB; j++) begin
      c_into[j*CLA_BLOCK_W] = blk_cin[j];
    end
  end

  logic [N-1:0] sum;
  logic         carry;

  // A partial top block has zeroed padding, so its group carry is not bit N's carry
  assign sum   = N'(p_pad ^ c_into);
  assign carry = (N % CLA_BLOCK_W == 0) ? blk_c[NB] : |(co_all & CO_SEL);

  logic [N-1:0] s_q, s_d;
  logic         c_out_q, c_out_d, out_valid_q, out_valid_d;

  always_comb begin
    s_d         = s_q;
    c_out_d     = c_out_q;
    out_valid_d = core_v;
    if (core_v) begin
      s_d     = sum;
      c_out_d = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q         <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_adder_reg.sv
// Self-checking bench for cla_adder_reg at N=2, 8 and 6 against an arithmetic reference model.
module tb_cla_adder_reg;

`ifdef CLA_ADDER_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] ia[3], ib[3];
  logic       ic[3], iv[3];

  logic [1:0] s2;
  logic [7:0] s8;
  logic [5:0] s6;
  logic       co2, co8, co6, ov2, ov8, ov6;

  cla_adder_reg #(.N(2)) u_n2 (
    .clk(clk), .reset(rst), .in_valid(iv[0]), .a(ia[0][1:0]), .b(ib[0][1:0]),
    .c_in(ic[0]), .s(s2), .c_out(co2), .out_valid(ov2)
  );
  cla_adder_reg #(.N(8)) u_n8 (
    .clk(clk), .reset(rst), .in_valid(iv[1]), .a(ia[1]), .b(ib[1]),
    .c_in(ic[1]), .s(s8), .c_out(co8), .out_valid(ov8)
  );
  cla_adder_reg #(.N(6)) u_n6 (
    .clk(clk), .reset(rst), .in_valid(iv[2]), .a(ia[2][5:0]), .b(ib[2][5:0]),
    .c_in(ic[2]), .s(s6), .c_out(co6), .out_valid(ov6)
  );

  logic [7:0] os[3];
  logic       oc[3], ov[3];
  assign os[0] = {6'b0, s2};
  assign os[1] = s8;
  assign os[2] = {2'b0, s6};
  assign oc[0] = co2;
  assign oc[1] = co8;
  assign oc[2] = co6;
  assign ov[0] = ov2;
  assign ov[1] = ov8;
  assign ov[2] = ov6;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: integer sum split into mod-2^W and carry, delayed by LAT edges
  function automatic int wid(input int k);
    case (k)
      0:       return 2;
      1:       return 8;
      default: return 6;
    endcase
  endfunction

  function automatic int fsum(input int k);
    return int'(ia[k]) + int'(ib[k]) + int'(ic[k]);
  endfunction

  logic [7:0] st_s[3], es[3];
  logic       st_c[3], st_v[3], ec[3], ev[3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        st_s[k] <= 8'd0; st_c[k] <= 1'b0; st_v[k] <= 1'b0;
        es[k]   <= 8'd0; ec[k]   <= 1'b0; ev[k]   <= 1'b0;
      end else begin
        st_v[k] <= iv[k];
        st_s[k] <= 8'(fsum(k) % (1 << wid(k)));
        st_c[k] <= 1'((fsum(k) >> wid(k)) & 1);
        if (LAT == 1) begin
          ev[k] <= iv[k];
          if (iv[k]) begin
            es[k] <= 8'(fsum(k) % (1 << wid(k)));
            ec[k] <= 1'((fsum(k) >> wid(k)) & 1);
          end
        end else begin
          ev[k] <= st_v[k];
          if (st_v[k]) begin
            es[k] <= st_s[k];
            ec[k] <= st_c[k];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_s_dut%0d", k), 32'(os[k]), 32'(es[k]));
        chk($sformatf("model_c_dut%0d", k), 32'(oc[k]), 32'(ec[k]));
        chk($sformatf("model_v_dut%0d", k), 32'(ov[k]), 32'(ev[k]));
      end
    end
  end

  task automatic drive(input int k, input int a, input int b, input int c, input int v);
    ia[k] = 8'(a);
    ib[k] = 8'(b);
    ic[k] = 1'(c);
    iv[k] = 1'(v);
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
  endtask

  // One transaction on dut k: measure latency to out_valid and check the literal result
  task automatic apply_chk(input int k, input int a, input int b, input int c,
                           input int exp_s, input int exp_c, input string nm);
    int cnt;
    idle();
    repeat (LAT) @(negedge clk);
    drive(k, a, b, c, 1);
    cnt = 0;
    do begin
      @(negedge clk);
      iv[k] = 1'b0;
      cnt++;
    end while (!ov[k] && cnt < 6);
    chk({nm, "_lat"}, 32'(cnt), 32'(LAT));
    chk({nm, "_s"}, 32'(os[k]), 32'(exp_s));
    chk({nm, "_c"}, 32'(oc[k]), 32'(exp_c));
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_s", 32'(os[1]), 32'd0);
    chk("reset_c", 32'(oc[1]), 32'd0);
    chk("reset_v", 32'(ov[1]), 32'd0);
    rst = 1'b0;

    // N=2 exhaustive sweep, c_in=0
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        drive(0, x, y, 0, 1);
        @(negedge clk);
      end
    end
    apply_chk(0, 3, 1, 0, 0, 1, "n2_3p1");

    // N=8 directed
    apply_chk(1, 255, 1, 0, 0, 1, "n8_255p1");
    apply_chk(1, 200, 100, 0, 44, 1, "n8_200p100");
    apply_chk(1, 0, 0, 1, 1, 0, "n8_cin");

    // N=8 stream at full throughput
    idle();
    repeat (LAT) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      drive(1, 3 * k, (5 * k) % 256, 0, 1);
      @(negedge clk);
    end
    idle();
    repeat (LAT) @(negedge clk);
    chk("stream_last_s", 32'(os[1]), 32'd120);

    // Hold while in_valid is low
    apply_chk(1, 7, 9, 0, 16, 0, "hold");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_s", 32'(os[1]), 32'd16);
      chk("hold_v", 32'(ov[1]), 32'd0);
    end
    apply_chk(1, 250, 10, 0, 4, 1, "resume");

    // Reset wins over a simultaneous valid input
    drive(1, 10, 20, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pri_s", 32'(os[1]), 32'd0);
    chk("rst_pri_c", 32'(oc[1]), 32'd0);
    chk("rst_pri_v", 32'(ov[1]), 32'd0);
    rst = 1'b0;
    idle();
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      chk("rst_no_emit_v", 32'(ov[1]), 32'd0);
      chk("rst_no_emit_s", 32'(os[1]), 32'd0);
    end

    // N=6 partial top block
    apply_chk(2, 63, 63, 1, 63, 1, "n6_full");
    apply_chk(2, 32, 31, 0, 63, 0, "n6_nocarry");
    apply_chk(2, 21, 43, 0, 0, 1, "n6_wrap");

    idle();
    repeat (LAT + 1) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
